// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer beside the ID stage: operand forwarding selects,
// load-use interlock, multi-cycle op stall FSM and a saturating stall counter.

module pipe_hazard_fwd (
    input  logic [4:0] src,
    input  logic       use_src,
    input  logic [4:0] ern,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] mrn,
    input  logic       mwreg,
    input  logic       mm2reg,
    output logic [1:0] sel,
    output logic       lu_hit
);
    logic exe_hit;
    logic mem_hit;

    assign exe_hit = ewreg & (ern != 5'd0) & (ern == src);
    assign mem_hit = mwreg & (mrn != 5'd0) & (mrn == src);

    // A load still in EXE has no data yet, so it cannot forward; it interlocks instead.
    always_comb begin
        sel = 2'd0;
        if (exe_hit && !em2reg)
            sel = 2'd1;
        else if (mem_hit)
            sel = mm2reg ? 2'd3 : 2'd2;
    end

    assign lu_hit = use_src & exe_hit & em2reg;
endmodule

module pipe_hazard_ctrl #(
    parameter int unsigned MC_LAT     = 8,
    parameter bit          DELAY_SLOT = 1'b1,
    parameter int unsigned CW         = 16
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic          use_rs,
    input  logic          use_rt,
    input  logic [4:0]    ern,
    input  logic          ewreg,
    input  logic          em2reg,
    input  logic [4:0]    mrn,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic          dbr_taken,
    input  logic          dmc_start,
    input  logic          stat_clr,
    output logic [1:0]    fwda,
    output logic [1:0]    fwdb,
    output logic          wpcir,
    output logic          bubble,
    output logic          flush_if,
    output logic          mc_busy,
    output logic [CW-1:0] stall_cnt
);
    localparam int unsigned NUM_OPS = 2;
    localparam logic [7:0]  MC_LOAD = 8'(MC_LAT - 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    logic [NUM_OPS-1:0][4:0] src;
    logic [NUM_OPS-1:0]      use_src;
    logic [NUM_OPS-1:0][1:0] sel;
    logic [NUM_OPS-1:0]      lu_hit;

    logic       lu;
    logic       start;
    logic       hold;
    state_t     state, next_state;
    logic [7:0] mc_cnt, next_cnt;
    logic       mc_done, next_done;

    assign src     = {rt, rs};
    assign use_src = {use_rt, use_rs};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        pipe_hazard_fwd u_fwd (
            .src     (src[g]),
            .use_src (use_src[g]),
            .ern     (ern),
            .ewreg   (ewreg),
            .em2reg  (em2reg),
            .mrn     (mrn),
            .mwreg   (mwreg),
            .mm2reg  (mm2reg),
            .sel     (sel[g]),
            .lu_hit  (lu_hit[g])
        );
    end

    assign lu    = |lu_hit;
    assign start = (state == IDLE) & dmc_start & ~lu & ~mc_done;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            mc_cnt  <= 8'd0;
            mc_done <= 1'b0;
        end else begin
            state   <= next_state;
            mc_cnt  <= next_cnt;
            mc_done <= next_done;
        end
    end

    // The start cycle is the first held cycle, so RUN lasts MC_LAT-1 cycles and
    // leaves once the count would reach zero; MC_LAT=1 never enters RUN.
    always_comb begin
        next_state = state;
        next_cnt   = mc_cnt;
        next_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_cnt = MC_LOAD;
                    if (MC_LOAD == 8'd0)
                        next_done = 1'b1;
                    else
                        next_state = RUN;
                end
            end
            RUN: begin
                next_cnt = mc_cnt - 8'd1;
                if (mc_cnt <= 8'd1) begin
                    next_state = IDLE;
                    next_cnt   = 8'd0;
                    next_done  = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 8'd0;
            end
        endcase
    end

    // Outputs are forced to their pass-through values while reset is held.
    always_comb begin
        hold     = clrn & (lu | start | (state == RUN));
        wpcir    = ~hold;
        bubble   = hold;
        mc_busy  = clrn & (state == RUN);
        flush_if = clrn & ~DELAY_SLOT & dbr_taken & ~hold;
        fwda     = clrn ? sel[0] : 2'd0;
        fwdb     = clrn ? sel[1] : 2'd0;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            stall_cnt <= '0;
        else if (stat_clr)
            stall_cnt <= '0;
        else if (!wpcir && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic checked
// every cycle against a behavioural model of the hazard rules.

module tb_pipe_hazard_ctrl;
    localparam int MC_LAT = 8;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic [4:0]    rs = 0, rt = 0, ern = 0, mrn = 0;
    logic          use_rs = 0, use_rt = 0, ewreg = 0, em2reg = 0;
    logic          mwreg = 0, mm2reg = 0, dbr_taken = 0, dmc_start = 0, stat_clr = 0;
    logic [1:0]    fwda, fwdb;
    logic          wpcir, bubble, flush_if, mc_busy;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .DELAY_SLOT(1'b0), .CW(CW)) dut (
        .clk(clk), .clrn(clrn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .mrn(mrn), .mwreg(mwreg),
        .mm2reg(mm2reg), .dbr_taken(dbr_taken), .dmc_start(dmc_start),
        .stat_clr(stat_clr), .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir),
        .bubble(bubble), .flush_if(flush_if), .mc_busy(mc_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_rem;   // further cycles the multi-cycle op keeps the pipe held
    bit m_done;  // the held op issues this cycle
    int m_cnt;

    function automatic int fwd_exp(input int src);
        if (ewreg && ern != 0 && ern == src && !em2reg) return 1;
        if (mwreg && mrn != 0 && mrn == src) return mm2reg ? 3 : 2;
        return 0;
    endfunction

    function automatic bit lu_exp();
        return ewreg && em2reg && ern != 0 &&
               ((use_rs && ern == rs) || (use_rt && ern == rt));
    endfunction

    function automatic bit start_exp();
        return m_rem == 0 && dmc_start && !lu_exp() && !m_done;
    endfunction

    function automatic bit hold_exp();
        return lu_exp() || m_rem > 0 || start_exp();
    endfunction

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_rem = 0; m_done = 0; m_cnt = 0;
        end else begin
            bit h, st;
            h  = hold_exp();
            st = start_exp();
            if (stat_clr) m_cnt = 0;
            else if (h && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (m_rem > 0) begin
                m_rem  = m_rem - 1;
                m_done = (m_rem == 0);
            end else if (st) begin
                m_rem  = MC_LAT - 1;
                m_done = (MC_LAT == 1);
            end else begin
                m_done = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!clrn) begin
            chk("rst_wpcir", int'(wpcir), 1);
            chk("rst_bubble", int'(bubble), 0);
            chk("rst_flush", int'(flush_if), 0);
            chk("rst_fwda", int'(fwda), 0);
            chk("rst_fwdb", int'(fwdb), 0);
            chk("rst_busy", int'(mc_busy), 0);
            chk("rst_cnt", int'(stall_cnt), 0);
        end else begin
            bit h;
            h = hold_exp();
            chk("fwda", int'(fwda), fwd_exp(int'(rs)));
            chk("fwdb", int'(fwdb), fwd_exp(int'(rt)));
            chk("wpcir", int'(wpcir), int'(!h));
            chk("bubble", int'(bubble), int'(h));
            chk("flush_if", int'(flush_if), int'(dbr_taken && !h));
            chk("mc_busy", int'(mc_busy), int'(m_rem > 0));
            chk("stall_cnt", int'(stall_cnt), m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic quiet();
        rs = 0; rt = 0; ern = 0; mrn = 0; use_rs = 0; use_rt = 0;
        ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
        dbr_taken = 0; dmc_start = 0; stat_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        int nstall, nbusy, s0;
        quiet();
        clrn = 0;
        repeat (2) tick();
        #1 chk("reset_wpcir", int'(wpcir), 1);
        chk("reset_cnt", int'(stall_cnt), 0);
        clrn = 1;
        tick();

        // EXE forwarding and EXE-over-MEM priority
        ewreg = 1; ern = 5; rs = 5; #1;
        chk("t1_fwda_exe", int'(fwda), 1);
        mwreg = 1; mrn = 5; #1;
        chk("t1_fwda_prio", int'(fwda), 1);
        tick(); quiet();

        // MEM load data forwarding; r0 never forwards
        mwreg = 1; mm2reg = 1; mrn = 7; rt = 7; #1;
        chk("t2_fwdb_load", int'(fwdb), 3);
        mrn = 0; rt = 0; #1;
        chk("t2_fwdb_r0", int'(fwdb), 0);
        tick(); quiet();

        // Load-use: one stall cycle, then forward from MEM
        s0 = int'(stall_cnt);
        ewreg = 1; em2reg = 1; ern = 9; use_rt = 1; rt = 9; #1;
        chk("t3_lu_wpcir", int'(wpcir), 0);
        chk("t3_lu_bubble", int'(bubble), 1);
        tick();
        ewreg = 0; em2reg = 0; ern = 0; mwreg = 1; mm2reg = 1; mrn = 9; #1;
        chk("t3_fwdb", int'(fwdb), 3);
        chk("t3_wpcir", int'(wpcir), 1);
        chk("t3_cnt", int'(stall_cnt), s0 + 1);
        tick(); quiet();

        // Multi-cycle op held MC_LAT cycles, issues on the next one
        stat_clr = 1; tick(); stat_clr = 0;
        dmc_start = 1;
        nstall = 0; nbusy = 0;
        for (int i = 0; i < MC_LAT; i++) begin
            #1;
            if (!wpcir) nstall++;
            if (mc_busy) nbusy++;
            tick();
        end
        #1;
        chk("t4_stalls", nstall, 8);
        chk("t4_busy", nbusy, 7);
        chk("t4_issue_wpcir", int'(wpcir), 1);
        chk("t4_cnt", int'(stall_cnt), 8);
        dmc_start = 0;
        tick(); quiet();

        // Taken branch during a load-use stall is not flushed
        dbr_taken = 1; ewreg = 1; em2reg = 1; ern = 3; use_rs = 1; rs = 3; #1;
        chk("t5_flush_stalled", int'(flush_if), 0);
        tick();
        ewreg = 0; em2reg = 0; #1;
        chk("t5_flush", int'(flush_if), 1);
        tick(); quiet();

        // Reset in the third RUN cycle aborts the op
        dmc_start = 1;
        repeat (3) tick();
        dmc_start = 0;
        #1 chk("t6_busy_before", int'(mc_busy), 1);
        clrn = 0; #1;
        chk("t6_wpcir", int'(wpcir), 1);
        chk("t6_busy", int'(mc_busy), 0);
        chk("t6_cnt", int'(stall_cnt), 0);
        tick(); clrn = 1; tick();
        #1 chk("t6_idle_wpcir", int'(wpcir), 1);

        // Saturation and clear
        ewreg = 1; em2reg = 1; ern = 4; use_rs = 1; rs = 4;
        repeat (20) tick();
        #1 chk("sat_cnt", int'(stall_cnt), 15);
        quiet(); stat_clr = 1; tick(); stat_clr = 0;
        #1 chk("clr_cnt", int'(stall_cnt), 0);
        tick();

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
            ern = 5'($urandom_range(0, 3)); mrn = 5'($urandom_range(0, 3));
            use_rs = 1'($urandom); use_rt = 1'($urandom);
            ewreg = 1'($urandom); em2reg = ($urandom_range(0, 2) == 0);
            mwreg = 1'($urandom); mm2reg = 1'($urandom);
            dbr_taken = 1'($urandom);
            dmc_start = ($urandom_range(0, 3) == 0);
            stat_clr = ($urandom_range(0, 49) == 0);
            clrn = ($urandom_range(0, 399) != 0);
            tick();
        end
        clrn = 1; quiet();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
